// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit bridging EX to data memory and WBU
//
// Purpose: accepts one memory op at a time from EX, issues it on a
// valid/ready request channel, waits for a response of any latency, then
// presents the (extended) result to WBU.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_*                  op from EX (valid/ready handshake, ready only in IDLE)
//   mem_req_*             aligned request: address, lane-shifted data, byte strobes
//   mem_rsp_valid/rdata   read data or write ack, honoured only in WAIT
//   out_*                 result toward WBU (valid/ready handshake)
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned accesses
// instead of issuing them; when undefined the access is aligned down.

module lsu_mem_port #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_we,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [4:0]        in_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic [4:0]        out_rd,
   output logic              out_misalign
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t state;

   // Latched op attributes needed when the response comes back
   logic             we_q;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [OFF_W-1:0] off_q;

   // Decode of the incoming op
   logic [1:0]       esize;
   logic [OFF_W-1:0] raw_off;
   logic [OFF_W-1:0] size_mask;
   logic [OFF_W-1:0] aligned_off;
   logic [NB-1:0]    strb_base;
   logic [NB-1:0]    strb;
   logic [XLEN-1:0]  wdata_sh;

   // A 32-bit datapath has no dword lane, so size 3 degrades to a word
   assign esize   = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;
   assign raw_off = in_addr[OFF_W-1:0];

   always_comb begin
      size_mask = '0;
      strb_base = '0;
      case (esize)
         2'd0: begin size_mask = OFF_W'(0); strb_base = NB'(1);  end
         2'd1: begin size_mask = OFF_W'(1); strb_base = NB'(3);  end
         2'd2: begin size_mask = OFF_W'(3); strb_base = NB'(15); end
         default: begin size_mask = OFF_W'(7); strb_base = '1;   end
      endcase
   end

   // Lane offset is forced onto the size boundary; a misaligned access is
   // either performed aligned down or trapped before it reaches memory.
   assign aligned_off = raw_off & ~size_mask;
   assign strb        = strb_base << aligned_off;
   assign wdata_sh    = in_wdata << {aligned_off, 3'b000};

   // Load extraction from the full-lane response
   logic [XLEN-1:0] rsp_sh;
   logic [XLEN-1:0] keep;
   logic            sign;
   logic [XLEN-1:0] load_ext;

   assign rsp_sh = mem_rsp_rdata >> {off_q, 3'b000};

   always_comb begin
      keep = '1;
      sign = 1'b0;
      case (size_q)
         2'd0: begin keep = XLEN'(8'hFF);          sign = rsp_sh[7];  end
         2'd1: begin keep = XLEN'(16'hFFFF);       sign = rsp_sh[15]; end
         2'd2: begin keep = XLEN'(32'hFFFF_FFFF);  sign = rsp_sh[31]; end
         default: begin keep = '1;                 sign = 1'b0;       end
      endcase
   end

   assign load_ext = (rsp_sh & keep) | ((sign && !uns_q) ? ~keep : '0);

   assign in_ready = (state == IDLE) && !rst;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = |(raw_off & size_mask);
`else
   assign out_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         size_q        <= 2'd0;
         uns_q         <= 1'b0;
         off_q         <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         out_valid     <= 1'b0;
         out_rdata     <= '0;
         out_rd        <= 5'd0;
`ifdef LSU_MISALIGN_TRAP_EN
         out_misalign  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  we_q          <= in_we;
                  size_q        <= esize;
                  uns_q         <= in_unsigned;
                  off_q         <= aligned_off;
                  out_rd        <= in_rd;
                  mem_req_we    <= in_we;
                  mem_req_addr  <= {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                  mem_req_wdata <= wdata_sh;
                  mem_req_wstrb <= strb;
`ifdef LSU_MISALIGN_TRAP_EN
                  out_misalign  <= misaligned;
                  if (misaligned) begin
                     out_rdata <= '0;
                     out_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     mem_req_valid <= 1'b1;
                     state         <= REQ;
                  end
`else
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
`endif
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               // For stores the response is only the write ack
               if (mem_rsp_valid) begin
                  out_rdata <= we_q ? '0 : load_ext;
                  out_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port (XLEN 32 and 64 in lockstep)

module tb_lsu_mem_port;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_we;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [31:0] in_addr;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_rdata;
   logic        out_ready;

   logic        a_in_ready, a_mem_req_valid, a_mem_req_we, a_out_valid, a_out_misalign;
   logic [31:0] a_mem_req_addr, a_mem_req_wdata, a_out_rdata;
   logic [3:0]  a_mem_req_wstrb;
   logic [4:0]  a_out_rd;

   logic        b_in_ready, b_mem_req_valid, b_mem_req_we, b_out_valid, b_out_misalign;
   logic [31:0] b_mem_req_addr;
   logic [63:0] b_mem_req_wdata, b_out_rdata;
   logic [7:0]  b_mem_req_wstrb;
   logic [4:0]  b_out_rd;

   int checks = 0;
   int errors = 0;

   lsu_mem_port #(.XLEN(32), .ADDR_W(32)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_we(in_we), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_rd(in_rd),
      .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(a_mem_req_we),
      .mem_req_addr(a_mem_req_addr), .mem_req_wdata(a_mem_req_wdata), .mem_req_wstrb(a_mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata[31:0]),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_rdata(a_out_rdata),
      .out_rd(a_out_rd), .out_misalign(a_out_misalign)
   );

   lsu_mem_port #(.XLEN(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_we(in_we), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(b_mem_req_we),
      .mem_req_addr(b_mem_req_addr), .mem_req_wdata(b_mem_req_wdata), .mem_req_wstrb(b_mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_rdata(b_out_rdata),
      .out_rd(b_out_rd), .out_misalign(b_out_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   // Reference: derived from the byte-lane rules with plain arithmetic
   function automatic void model(input int xlen, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 output logic req, output logic [31:0] eaddr,
                                 output logic [7:0] estrb, output logic [63:0] ewdata,
                                 output logic [63:0] erdata, output logic emis);
      int nb, sz, bytes, off;
      logic [63:0] xmask, bmask, v;
      logic mis;
      nb    = xlen / 8;
      sz    = (xlen == 32 && size == 2'd3) ? 2 : int'(size);
      bytes = 1 << sz;
      off   = int'(addr % 32'(nb));
      mis   = (off % bytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
      req  = !mis;
      emis = mis;
`else
      req  = 1'b1;
      emis = 1'b0;
      off  = off - (off % bytes);
`endif
      eaddr  = addr - (addr % 32'(nb));
      estrb  = 8'((((1 << bytes) - 1) << off) & ((1 << nb) - 1));
      xmask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      ewdata = (wdata << (8 * off)) & xmask;
      bmask  = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
      v      = ((rdata & xmask) >> (8 * off)) & bmask;
      if (!uns && v[8 * bytes - 1]) v = v | ~bmask;
      erdata = (we || !req) ? 64'd0 : (v & xmask);
   endfunction

   task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                         input logic [63:0] rdata, input int req_stall, input int rsp_delay,
                         input int out_stall);
      logic r32, r64, m32, m64;
      logic [31:0] ea32, ea64;
      logic [7:0]  es32, es64;
      logic [63:0] ew32, ew64, er32, er64;
      int n;
      model(32, we, size, uns, addr, wdata, rdata, r32, ea32, es32, ew32, er32, m32);
      model(64, we, size, uns, addr, wdata, rdata, r64, ea64, es64, ew64, er64, m64);

      @(negedge clk);
      in_we = we; in_size = size; in_unsigned = uns; in_addr = addr; in_wdata = wdata; in_rd = rd;
      in_valid = 1'b1;
      n = 0;
      while (!(a_in_ready && b_in_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(a_in_ready && b_in_ready)) begin
         errors++;
         $display("FAIL accept_timeout in_ready32=%b in_ready64=%b required 1", a_in_ready, b_in_ready);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;

      if (r32 && r64) begin
         checks++;
         if (a_mem_req_valid !== 1'b1 || b_mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_valid_latency got %b/%b required 1/1", a_mem_req_valid, b_mem_req_valid);
         end
         for (int s = 0; s < req_stall; s++) begin
            checks++;
            if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_mem_req_valid !== 1'b1 ||
                b_mem_req_valid !== 1'b1 || a_mem_req_addr !== ea32 || b_mem_req_addr !== ea64 ||
                a_mem_req_wstrb !== es32[3:0] || b_mem_req_wstrb !== es64) begin
               errors++;
               $display("FAIL req_hold cycle %0d ready=%b/%b valid=%b/%b addr=%h/%h required %h/%h",
                        s, a_in_ready, b_in_ready, a_mem_req_valid, b_mem_req_valid,
                        a_mem_req_addr, b_mem_req_addr, ea32, ea64);
            end
            @(negedge clk);
         end
         checks++;
         if (a_mem_req_addr !== ea32 || a_mem_req_wstrb !== es32[3:0] || a_mem_req_we !== we ||
             (we && a_mem_req_wdata !== ew32[31:0])) begin
            errors++;
            $display("FAIL req32 addr=%h strb=%b we=%b wdata=%h required %h %b %b %h",
                     a_mem_req_addr, a_mem_req_wstrb, a_mem_req_we, a_mem_req_wdata,
                     ea32, es32[3:0], we, ew32[31:0]);
         end
         checks++;
         if (b_mem_req_addr !== ea64 || b_mem_req_wstrb !== es64 || b_mem_req_we !== we ||
             (we && b_mem_req_wdata !== ew64)) begin
            errors++;
            $display("FAIL req64 addr=%h strb=%b we=%b wdata=%h required %h %b %b %h",
                     b_mem_req_addr, b_mem_req_wstrb, b_mem_req_we, b_mem_req_wdata,
                     ea64, es64, we, ew64);
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         for (int d = 0; d < rsp_delay; d++) begin
            checks++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
               errors++;
               $display("FAIL early_out_valid got %b/%b required 0/0", a_out_valid, b_out_valid);
            end
            @(negedge clk);
         end
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = rdata;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = $urandom();
      end else begin
         checks++;
         if (a_mem_req_valid !== 1'b0 || b_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_no_req got %b/%b required 0/0", a_mem_req_valid, b_mem_req_valid);
         end
      end

      checks++;
      if (a_out_valid !== 1'b1 || a_out_rdata !== er32[31:0] || a_out_rd !== rd || a_out_misalign !== m32) begin
         errors++;
         $display("FAIL out32 valid=%b rdata=%h rd=%0d mis=%b required 1 %h %0d %b",
                  a_out_valid, a_out_rdata, a_out_rd, a_out_misalign, er32[31:0], rd, m32);
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_rdata !== er64 || b_out_rd !== rd || b_out_misalign !== m64) begin
         errors++;
         $display("FAIL out64 valid=%b rdata=%h rd=%0d mis=%b required 1 %h %0d %b",
                  b_out_valid, b_out_rdata, b_out_rd, b_out_misalign, er64, rd, m64);
      end
      for (int s = 0; s < out_stall; s++) begin
         @(negedge clk);
         checks++;
         if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1 || a_out_rdata !== er32[31:0] ||
             b_out_rdata !== er64 || a_out_rd !== rd || b_out_rd !== rd || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL out_hold cycle %0d valid=%b/%b rdata=%h/%h required 1/1 %h/%h",
                     s, a_out_valid, b_out_valid, a_out_rdata, b_out_rdata, er32[31:0], er64);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release out_valid=%b/%b in_ready=%b/%b required 0/0 1/1",
                  a_out_valid, b_out_valid, a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_mem_req_valid !== 1'b0 ||
          b_mem_req_valid !== 1'b0 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0 ||
          a_out_rdata !== 32'd0 || b_out_rdata !== 64'd0 || a_out_rd !== 5'd0 ||
          a_mem_req_wstrb !== 4'd0 || b_mem_req_addr !== 32'd0 || a_out_misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_state in_ready=%b/%b req_valid=%b/%b out_valid=%b/%b rdata=%h required all 0",
                  a_in_ready, b_in_ready, a_mem_req_valid, b_mem_req_valid, a_out_valid, b_out_valid, a_out_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready=%b/%b required 1/1", a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_directed();
      run_op(1'b1, 2'd0, 1'b0, 32'h8000_0003, 64'h0000_00AB, 5'd3, 64'd0, 0, 0, 0);
      run_op(1'b0, 2'd0, 1'b0, 32'h8000_0001, 64'd0, 5'd7, 64'h0000_0000_1234_80FF, 0, 0, 0);
      run_op(1'b0, 2'd0, 1'b1, 32'h8000_0001, 64'd0, 5'd8, 64'h0000_0000_1234_80FF, 0, 1, 0);
      run_op(1'b0, 2'd1, 1'b0, 32'h8000_0002, 64'd0, 5'd9, 64'h0000_0000_8001_0000, 0, 0, 0);
      run_op(1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'd0, 5'd10, 64'hFEDC_BA98_7654_3210, 0, 0, 0);
      run_op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'd0, 5'd11, 64'h8765_4321_0FED_CBA9, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      run_op(1'b1, 2'd1, 1'b0, 32'h8000_0012, 64'h0000_BEEF, 5'd12, 64'd0, 3, 2, 2);
      run_op(1'b0, 2'd2, 1'b0, 32'h8000_0020, 64'd0, 5'd13, 64'hA5A5_5A5A_F00D_CAFE, 3, 0, 2);
   endtask

   task automatic test_misalign();
      run_op(1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'd0, 5'd14, 64'h1122_3344_5566_7788, 0, 0, 0);
      run_op(1'b1, 2'd2, 1'b0, 32'h8000_0002, 64'hCAFE_F00D, 5'd15, 64'd0, 0, 0, 0);
      run_op(1'b0, 2'd1, 1'b1, 32'h8000_0007, 64'd0, 5'd16, 64'h8899_AABB_CCDD_EEFF, 1, 0, 1);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [1:0]  size;
      for (int i = 0; i < 40; i++) begin
         size = 2'($urandom_range(0, 3));
         addr = $urandom();
`ifdef LSU_MISALIGN_TRAP_EN
         // keep both widths agreeing on whether a dword is misaligned
         if (size == 2'd3 && addr[1:0] == 2'b00) addr[2] = 1'b0;
`endif
         run_op(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
                {$urandom(), $urandom()}, 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      in_we = 1'b0; in_size = 2'd2; in_unsigned = 1'b0; in_addr = 32'h8000_0004; in_rd = 5'd21;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL in_ready_during_rst got %b/%b required 0/0", a_in_ready, b_in_ready);
      end
      rst = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_mem_req_valid !== 1'b0 ||
             b_mem_req_valid !== 1'b0 || a_in_ready !== 1'b1 || b_in_ready !== 1'b1 ||
             a_out_rdata !== 32'd0 || b_out_rdata !== 64'd0) begin
            errors++;
            $display("FAIL rst_in_wait cycle %0d out_valid=%b/%b req_valid=%b/%b in_ready=%b/%b rdata=%h required 0 0 1 0",
                     c, a_out_valid, b_out_valid, a_mem_req_valid, b_mem_req_valid,
                     a_in_ready, b_in_ready, a_out_rdata);
         end
      end
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
      in_addr = 32'd0; in_wdata = 64'd0; in_rd = 5'd0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0; out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_misalign();
      test_random();
      test_reset_in_wait();
      run_op(1'b0, 2'd0, 1'b0, 32'h8000_0042, 64'd0, 5'd30, 64'h0000_0000_00C3_0000, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
